minions_led_sequencer: RTL and testbench
========================================

# minions_led_sequencer

LED pattern sequencer that sits directly downstream of the Nios II output PIO. It consumes the PIO's 8-bit `out_port` as a command byte and drives the board LEDs with a static-off, rotating, bouncing or blinking pattern. Patterns advance on an internal prescaled tick, so software only writes one command byte per pattern change.

## Interface
- `TICK_DIV`, default 12500000: base step period in `clk` cycles. Legal range 1..2^29.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `cmd`  in  8  command byte, driven directly from the PIO `out_port` in the same clock domain.
  - `cmd[7:6]` mode: 00 OFF, 01 ROTATE, 10 BOUNCE, 11 BLINK.
  - `cmd[5:4]` speed.
  - `cmd[3:0]` seed.
- `leds`  out  8  LED pattern, registered.
- `tick`  out  1  one-cycle pulse, registered; high in the cycle after `leds` advances.
- `active`  out  1  high while the FSM is in RUN.

## Operation
- Registers:
  - `cmd_q[7:0]`: last accepted command.
  - `state`: IDLE, LOAD or RUN.
  - `cnt[31:0]`: prescaler.
  - `dir`: bounce direction, 0 = left toward bit 7.
  - `leds`.
- Step period `P = TICK_DIV * (speed + 1)`, computed 32 bits wide and recomputed from `cmd_q`.
- Change detect: any cycle with `cmd != cmd_q` (any state):
  - `cmd_q <= cmd`, `cnt <= 0`, `state <= LOAD`.
  - `leds` is held this cycle.
- Rewriting the same byte is not a change and does not restart the pattern.
- LOAD, one cycle, loads the initial pattern from `cmd_q`, then:
  - OFF: `leds <= 0`, go to IDLE.
  - ROTATE: `leds <= {4'h0, seed}`, go to RUN.
  - BOUNCE: `leds <= 1 << seed[2:0]`, `dir <= (seed[2:0]==7)`, go to RUN. `seed[3]` is ignored.
  - BLINK: `leds <= {seed, seed}`, go to RUN.
- RUN, each cycle:
  - If `cnt == P-1`: `cnt <= 0` and step the pattern; otherwise `cnt <= cnt+1`.
- Pattern steps:
  - ROTATE: `leds <= {leds[6:0], leds[7]}`. Seed 0 stays all-zero but still ticks.
  - BOUNCE:
    - If `dir==0 && leds[7]`: `dir <= 1`, `leds <= leds>>1`.
    - Else if `dir==1 && leds[0]`: `dir <= 0`, `leds <= leds<<1`.
    - Else shift in the current direction.
    - The end bit is shown for exactly one period.
  - BLINK: `leds <= (leds==0) ? {seed,seed} : 0`.
- IDLE: `leds` holds 0, `cnt` holds 0, `tick` stays 0.
- Change detect has priority over a coincident step; the step is discarded.

## Timing
- Reset values:
  - `leds = 0`, `tick = 0`, `active = 0`.
  - `state = IDLE`, `cmd_q = 0`, `cnt = 0`, `dir = 0`.
- Command latency:
  - `cmd` changes before edge N; change is detected at edge N.
  - Initial pattern is visible after edge N+1.
  - `active` goes high after edge N+1.
- First step lands at edge N+1+P; `tick` is high for the following cycle. Each later step follows P cycles after the previous one.
- Leaving reset with `cmd != 0` is a change at the first edge, so the pattern appears 2 edges after reset release.
- Mid-run command change: the pattern freezes for one cycle, then reloads. There is no partial step and `tick` is not asserted.
- `reset_n` asserted mid-pattern clears all outputs immediately (asynchronous). No step is pending after release.

## Test plan
Bench uses `TICK_DIV = 4`.
- Reset with `cmd = 0x00`, hold 20 cycles -> `leds = 0`, `tick` never high, `active = 0`.
- `cmd = 0x43` (ROTATE, speed 0, seed 3):
  - `leds = 0x03` two edges after the change.
  - Then `0x06`, `0x0C`, `0x18`, … every 4 cycles, one `tick` per step.
  - `0xC0` -> `0x81` wrap checked.
- `cmd = 0x86` (BOUNCE, seed 6):
  - Sequence `0x40, 0x80, 0x40, 0x20, …, 0x01, 0x02`.
  - Each value held 4 cycles; `0x80` and `0x01` each shown once per pass.
- `cmd = 0xF5` (BLINK, speed 3):
  - `0x55`, then `0x00`, `0x55`, … alternating every 16 cycles.
- Rewrite `0x43` during ROTATE -> no restart.
- Write `0x44` on the cycle `cnt == P-1` -> step discarded, `leds` reloads to `0x04`, no `tick`.
- Pulse `reset_n` low mid-BOUNCE -> `leds = 0` with no clock edge required.
- After release with `cmd` still `0x86` -> `0x40` reappears 2 edges later.

Source files
------------

// File: rtl/minions_led_sequencer.sv
// minions_led_sequencer: turns a PIO command byte into off/rotate/bounce/blink LED patterns
module minions_led_sequencer #(
  parameter int unsigned TICK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] cmd,
  output logic [7:0] leds,
  output logic       tick,
  output logic       active
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t      state, state_d;
  logic [7:0]  cmd_q, cmd_q_d, leds_d, load_leds, step_leds;
  logic [31:0] cnt, cnt_d, period;
  logic        dir, dir_d, tick_d, step_dir;
  logic [1:0]  mode;
  logic [3:0]  seed;
  assign mode   = cmd_q[7:6];
  assign seed   = cmd_q[3:0];
  assign period = 32'(TICK_DIV) * (32'(cmd_q[5:4]) + 32'd1);
  assign active = state == RUN;
  assign load_leds = mode == 2'd0 ? 8'h00 :
                     mode == 2'd1 ? {4'h0, seed} :
                     mode == 2'd2 ? 8'd1 << seed[2:0] : {seed, seed};
  // Bounce turns around when the lit bit reaches the end it is heading to, so that end shows for one full period.
  assign step_dir  = dir ^ (dir ? leds[0] : leds[7]);
  assign step_leds = mode == 2'd1 ? {leds[6:0], leds[7]} :
                     mode == 2'd2 ? (step_dir ? leds >> 1 : leds << 1) :
                     mode == 2'd3 ? (leds == 8'h00 ? {seed, seed} : 8'h00) : 8'h00;
  // Next-state: a new command always wins and freezes the LEDs for one cycle; otherwise load, step or idle.
  always_comb begin
    state_d = state;
    cmd_q_d = cmd_q;
    cnt_d   = cnt;
    dir_d   = dir;
    leds_d  = leds;
    tick_d  = 1'b0;
    if (cmd != cmd_q) begin
      cmd_q_d = cmd;
      cnt_d   = 32'd0;
      state_d = LOAD;
    end else if (state == LOAD) begin
      cnt_d   = 32'd0;
      leds_d  = load_leds;
      dir_d   = mode == 2'd2 ? seed[2:0] == 3'd7 : dir;
      state_d = mode == 2'd0 ? IDLE : RUN;
    end else if (state == RUN) begin
      cnt_d  = cnt == period - 32'd1 ? 32'd0 : cnt + 32'd1;
      tick_d = cnt == period - 32'd1;
      leds_d = tick_d ? step_leds : leds;
      dir_d  = tick_d && mode == 2'd2 ? step_dir : dir;
    end else begin
      cnt_d  = 32'd0;
      leds_d = 8'h00;
    end
  end
  // State register with asynchronous clear of every output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cmd_q <= 8'h00;
      cnt   <= 32'd0;
      dir   <= 1'b0;
      leds  <= 8'h00;
      tick  <= 1'b0;
    end else begin
      state <= state_d;
      cmd_q <= cmd_q_d;
      cnt   <= cnt_d;
      dir   <= dir_d;
      leds  <= leds_d;
      tick  <= tick_d;
    end
  end
endmodule

// File: tb/tb_minions_led_sequencer.sv
// tb_minions_led_sequencer: random and directed checks against a step-count model of the LED sequencer
module tb_minions_led_sequencer;
  localparam int TD = 4;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic [7:0] leds;
  logic       tick, active;
  int         checks = 0, errors = 0;
  logic       chk_en = 1'b0;
  logic [7:0] m_cmd = 8'h00, m_held = 8'h00;
  int         m_state = 0;
  int         m_e = 0;

  minions_led_sequencer #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset_n(reset_n), .cmd(cmd), .leds(leds), .tick(tick), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input logic [7:0] c, input int n);
    logic [15:0] r;
    int ph;
    r = 16'({4'h0, c[3:0]}) << (n % 8);
    ph = (int'(c[2:0]) + n) % 14;
    case (c[7:6])
      2'd1: return r[7:0] | r[15:8];
      2'd2: return 8'd1 << (ph <= 7 ? ph : 14 - ph);
      2'd3: return (n % 2 == 0) ? {c[3:0], c[3:0]} : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int per(input logic [7:0] c);
    return TD * (int'(c[5:4]) + 1);
  endfunction

  function automatic logic [7:0] exp_leds();
    return m_state == 1 ? m_held : m_state == 2 ? pat(m_cmd, m_e / per(m_cmd)) : 8'h00;
  endfunction

  function automatic logic exp_tick();
    return m_state == 2 && m_e > 0 && m_e % per(m_cmd) == 0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cmd <= 8'h00; m_state <= 0; m_e <= 0; m_held <= 8'h00;
    end else if (cmd != m_cmd) begin
      m_held <= exp_leds(); m_cmd <= cmd; m_state <= 1;
    end else if (m_state == 1) begin
      m_state <= m_cmd[7:6] == 2'd0 ? 0 : 2; m_e <= 0;
    end else if (m_state == 2) begin
      m_e <= m_e + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_leds", leds, exp_leds());
      chk("model_tick", 8'(tick), 8'(exp_tick()));
      chk("model_active", 8'(active), 8'(m_state == 2));
    end
  end

  task automatic set_cmd(input logic [7:0] c);
    @(negedge clk);
    cmd = c;
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] rot [7] = '{8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
  logic [7:0] bnc [10] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_leds", leds, 8'h00);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("off_leds", leds, 8'h00);
    chk("off_active", 8'(active), 8'h00);
    set_cmd(8'h43);
    chk("rot_load", leds, 8'h03);
    chk("rot_active", 8'(active), 8'h01);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) cmd = 8'h43;
      repeat (4) @(negedge clk);
      chk("rot_step", leds, rot[i]);
      chk("rot_tick", 8'(tick), 8'h01);
    end
    repeat (3) @(negedge clk);
    cmd = 8'h44;
    @(negedge clk);
    chk("disc_hold", leds, 8'h81);
    chk("disc_tick", 8'(tick), 8'h00);
    @(negedge clk);
    chk("disc_load", leds, 8'h04);
    chk("disc_tick2", 8'(tick), 8'h00);
    set_cmd(8'h86);
    chk("bnc_load", leds, 8'h40);
    for (int i = 0; i < 10; i++) begin
      repeat (4) @(negedge clk);
      chk("bnc_step", leds, bnc[i]);
    end
    set_cmd(8'hF5);
    chk("blk_load", leds, 8'h55);
    for (int i = 0; i < 3; i++) begin
      repeat (16) @(negedge clk);
      chk("blk_step", leds, i % 2 == 0 ? 8'h00 : 8'h55);
    end
    set_cmd(8'h86);
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("async_leds", leds, 8'h00);
    chk("async_active", 8'(active), 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_hold", leds, 8'h00);
    @(negedge clk);
    chk("rel_load", leds, 8'h40);
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(1, 40)) @(negedge clk);
      case ($urandom_range(0, 9))
        0: begin #2 reset_n = 1'b0; @(negedge clk); reset_n = 1'b1; end
        1: cmd = cmd;
        2: cmd = {cmd[7:6], 6'($urandom)};
        default: cmd = 8'($urandom);
      endcase
    end
    repeat (5) @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
